// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO feeding a UART transmitter through a start/ready
// handshake. A byte is popped only when a new frame is launched. If the
// transmitter never drops tx_ready, the same byte is re-launched after
// RETRY_CYC idle cycles.
module uart_tx_feeder #(
    parameter int DEPTH     = 16,
    parameter int RETRY_CYC = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_ready,
    output logic                   busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = (RETRY_CYC > 1) ? $clog2(RETRY_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t         state;
    state_t         state_n;

    logic [7:0]     mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count_n;
    logic           push;
    logic           pop;

    logic [RW-1:0]  retry;
    logic [RW-1:0]  retry_n;
    logic           tx_start_n;
    logic [7:0]     tx_data_n;

    // A push is only accepted while the registered full flag is clear.
    assign push = wr_en & ~full;
    assign busy = (state != IDLE) | ~empty;

    // Next occupancy from push/pop; a pop and a push together leave it unchanged.
    always_comb begin
        count_n = count;
        case ({push, pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers, occupancy flags and the overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count    <= count_n;
            empty    <= (count_n == '0);
            full     <= (count_n == CW'(DEPTH));
            overflow <= wr_en & full;
        end
    end

    // Launch/retry FSM: next state, pop decision and next transmitter outputs.
    always_comb begin
        state_n    = state;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data;
        retry_n    = retry;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty && tx_ready) begin
                    pop        = 1'b1;
                    tx_data_n  = mem[rd_ptr];
                    tx_start_n = 1'b1;
                    state_n    = LAUNCH;
                end
            end
            LAUNCH: begin
                retry_n = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_n = WAIT_DONE;
                end else if (retry == RW'(RETRY_CYC - 1)) begin
                    // Transmitter ignored the start: re-issue the same byte.
                    tx_start_n = 1'b1;
                    state_n    = LAUNCH;
                end else begin
                    retry_n = retry + RW'(1);
                end
            end
            WAIT_DONE: begin
                if (tx_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state and registered transmitter outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
            retry    <= '0;
        end else begin
            state    <= state_n;
            tx_start <= tx_start_n;
            tx_data  <= tx_data_n;
            retry    <= retry_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Testbench for uart_tx_feeder: queue-based reference model of the FIFO and
// frame sequence, plus a behavioural UART transmitter driving tx_ready.
module tb_uart_tx_feeder;

    localparam int DEPTH     = 16;
    localparam int RETRY_CYC = 4;
    localparam int CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          overflow;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic          busy;

    uart_tx_feeder #(
        .DEPTH     (DEPTH),
        .RETRY_CYC (RETRY_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;

    // Reference model state
    byte unsigned q[$];
    byte unsigned sent[$];
    byte unsigned accepted[$];
    logic [7:0]  exp_data = 8'h00;
    logic        exp_ovf  = 1'b0;
    bit          awaiting = 1'b0;
    int          cyc       = 0;
    int          n_starts  = 0;
    int          proto_err = 0;
    int          mon_bad   = 0;
    string       mon_msg   = "";

    // Transmitter model state
    bit          auto_xmt  = 1'b0;
    int          frame_len = 176;
    int          busy_left = 0;

    // One clock cycle: advance the transmitter model and the reference model.
    task automatic step();
        logic          start_pre;
        logic          ready_pre;
        logic          wr_pre;
        logic          rst_pre;
        logic [7:0]    d_pre;
        bit            full_pre;
        logic [CW-1:0] exp_count;
        start_pre = tx_start;
        ready_pre = tx_ready;
        wr_pre    = wr_en;
        rst_pre   = rst;
        d_pre     = wr_data;
        full_pre  = (q.size() == DEPTH);
        @(posedge clk);
        #1;
        cyc++;
        if (auto_xmt) begin
            if (start_pre === 1'b1 && ready_pre === 1'b1) begin
                tx_ready  = 1'b0;
                busy_left = frame_len;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) tx_ready = 1'b1;
            end
        end
        if (rst_pre === 1'b1) begin
            q.delete();
            exp_data = 8'h00;
            exp_ovf  = 1'b0;
            awaiting = 1'b0;
            if (tx_start !== 1'b0) proto_err++;
        end else begin
            if (awaiting && ready_pre === 1'b0) awaiting = 1'b0;
            if (tx_start === 1'b1) begin
                n_starts++;
                if (start_pre === 1'b1 || ready_pre !== 1'b1) proto_err++;
                if (!awaiting) begin
                    if (q.size() == 0) begin
                        proto_err++;
                    end else begin
                        exp_data = q.pop_front();
                        sent.push_back(tx_data);
                    end
                    awaiting = 1'b1;
                end
            end
            exp_ovf = (wr_pre === 1'b1) && full_pre;
            if (wr_pre === 1'b1 && !full_pre) begin
                q.push_back(d_pre);
                accepted.push_back(d_pre);
            end
        end
        exp_count = CW'(q.size());
        if (count !== exp_count || full !== (q.size() == DEPTH) || empty !== (q.size() == 0) ||
            overflow !== exp_ovf || tx_data !== exp_data) begin
            if (mon_bad == 0)
                mon_msg = $sformatf("cyc %0d count=%0d/%0d full=%b empty=%b ovf=%b/%b data=%h/%h",
                                    cyc, count, exp_count, full, empty, overflow, exp_ovf, tx_data, exp_data);
            mon_bad++;
        end
    endtask

    // Run until model queue, DUT and transmitter are all idle, or the bound expires.
    task automatic drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (q.size() == 0 && busy === 1'b0 && busy_left == 0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h77; tx_ready = 1'b1; auto_xmt = 1'b0;
        step();
        step();
        rst = 1'b0; wr_en = 1'b0;
        n_checks++;
        if ({count, empty, full, overflow} !== {CW'(0), 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b overflow=%b, required 0 1 0 0",
                     count, empty, full, overflow);
        end
        n_checks++;
        if ({tx_start, tx_data, busy} !== {1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_tx: tx_start=%b tx_data=%h busy=%b, required 0 00 0", tx_start, tx_data, busy);
        end
        for (int i = 0; i < 6; i++) step();
        n_checks++;
        if (empty !== 1'b1 || n_starts !== 0) begin
            n_fail++;
            $display("FAIL reset_wr_ignored: empty=%b starts=%0d, required 1 0", empty, n_starts);
        end
        n_checks++;
        if (mon_bad !== 0 || proto_err !== 0) begin
            n_fail++;
            $display("FAIL reset_monitor: mismatches=%0d proto=%0d (%s), required 0 0", mon_bad, proto_err, mon_msg);
        end
    endtask

    task automatic test_min_latency();
        bit ok;
        sent.delete(); mon_bad = 0; proto_err = 0;
        auto_xmt = 1'b1; frame_len = 176; tx_ready = 1'b1;
        wr_en = 1'b1; wr_data = 8'hA5;
        step();
        wr_en = 1'b0;
        n_checks++;
        if (tx_start !== 1'b0 || empty !== 1'b0 || count !== CW'(1)) begin
            n_fail++;
            $display("FAIL latency_push: tx_start=%b empty=%b count=%0d, required 0 0 1", tx_start, empty, count);
        end
        step();
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'hA5 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_start: tx_start=%b tx_data=%h empty=%b, required 1 a5 1", tx_start, tx_data, empty);
        end
        step();
        n_checks++;
        if (tx_start !== 1'b0 || tx_data !== 8'hA5) begin
            n_fail++;
            $display("FAIL start_one_cycle: tx_start=%b tx_data=%h, required 0 a5", tx_start, tx_data);
        end
        drain(600, ok);
        n_checks++;
        if (!ok || sent.size() != 1 || mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL latency_drain: done=%b frames=%0d mismatches=%0d proto=%0d (%s), required 1 1 0 0",
                     ok, sent.size(), mon_bad, proto_err, mon_msg);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit bad;
        int s0;
        sent.delete(); mon_bad = 0; proto_err = 0; s0 = n_starts;
        wr_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            wr_data = 8'(i);
            step();
        end
        wr_en = 1'b0;
        drain(1000, ok);
        bad = (sent.size() != 3);
        if (!bad) for (int i = 0; i < 3; i++) if (sent[i] != 8'(i + 1)) bad = 1'b1;
        n_checks++;
        if (!ok || bad || (n_starts - s0) != 3) begin
            n_fail++;
            $display("FAIL b2b_order: done=%b starts=%0d sent=%p, required 1 3 '{1,2,3}", ok, n_starts - s0, sent);
        end
        n_checks++;
        if (mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL b2b_monitor: mismatches=%0d proto=%0d (%s), required 0 0", mon_bad, proto_err, mon_msg);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        bit bad;
        sent.delete(); mon_bad = 0; proto_err = 0;
        auto_xmt = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
            if (i == 15) begin
                n_checks++;
                if (full !== 1'b1 || count !== CW'(16) || overflow !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fill_16: full=%b count=%0d overflow=%b, required 1 16 0", full, count, overflow);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || full !== 1'b1 || count !== CW'(16)) begin
            n_fail++;
            $display("FAIL overflow_17th: overflow=%b full=%b count=%0d, required 1 1 16", overflow, full, count);
        end
        wr_en = 1'b0;
        step();
        n_checks++;
        if (overflow !== 1'b0 || count !== CW'(16)) begin
            n_fail++;
            $display("FAIL overflow_pulse: overflow=%b count=%0d, required 0 16", overflow, count);
        end
        tx_ready = 1'b1; auto_xmt = 1'b1;
        drain(4000, ok);
        bad = (sent.size() != 16);
        if (!bad) for (int i = 0; i < 16; i++) if (sent[i] != 8'(i)) bad = 1'b1;
        n_checks++;
        if (!ok || bad || mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL overflow_drain: done=%b sent=%p mismatches=%0d proto=%0d, required 1 00..0f 0 0",
                     ok, sent, mon_bad, proto_err);
        end
    endtask

    task automatic test_full_pop_push();
        bit ok;
        bit bad;
        logic [7:0] fill [16];
        sent.delete(); mon_bad = 0; proto_err = 0;
        auto_xmt = 1'b0; tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom); fill[i] = wr_data;
            step();
        end
        wr_data = 8'h55; tx_ready = 1'b1;
        step();
        wr_en = 1'b0; auto_xmt = 1'b1;
        n_checks++;
        if (overflow !== 1'b1 || count !== CW'(15) || tx_start !== 1'b1 || tx_data !== fill[0]) begin
            n_fail++;
            $display("FAIL full_pop_push: overflow=%b count=%0d tx_start=%b tx_data=%h, required 1 15 1 %h",
                     overflow, count, tx_start, tx_data, fill[0]);
        end
        drain(4000, ok);
        bad = (sent.size() != 16);
        if (!bad) for (int i = 0; i < 16; i++) if (sent[i] != fill[i]) bad = 1'b1;
        n_checks++;
        if (!ok || bad || mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL full_pop_push_drain: done=%b frames=%0d order_bad=%b mismatches=%0d proto=%0d, required 1 16 0 0 0",
                     ok, sent.size(), bad, mon_bad, proto_err);
        end
    endtask

    task automatic test_retry();
        bit ok;
        int bad;
        int first_gap;
        int starts[$];
        logic [7:0] b0;
        logic [7:0] b1;
        sent.delete(); mon_bad = 0; proto_err = 0;
        auto_xmt = 1'b0; tx_ready = 1'b1;
        b0 = 8'($urandom); b1 = 8'($urandom);
        wr_en = 1'b1; wr_data = b0;
        step();
        wr_data = b1;
        step();
        wr_en = 1'b0;
        if (tx_start === 1'b1) starts.push_back(cyc);
        for (int i = 0; i < 25; i++) begin
            step();
            if (tx_start === 1'b1) starts.push_back(cyc);
        end
        n_checks++;
        if (starts.size() != 6) begin
            n_fail++;
            $display("FAIL retry_pulses: starts=%0d, required 6", starts.size());
        end
        bad = 0; first_gap = 0;
        for (int i = 1; i < starts.size(); i++) begin
            if (starts[i] - starts[i-1] != RETRY_CYC + 1) begin
                if (bad == 0) first_gap = starts[i] - starts[i-1];
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL retry_period: gap=%0d, required %0d", first_gap, RETRY_CYC + 1);
        end
        n_checks++;
        if (count !== CW'(1) || tx_data !== b0) begin
            n_fail++;
            $display("FAIL retry_hold: count=%0d tx_data=%h, required 1 %h", count, tx_data, b0);
        end
        auto_xmt = 1'b1;
        drain(1000, ok);
        n_checks++;
        if (!ok || sent.size() != 2 || mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL retry_drain: done=%b sent=%p mismatches=%0d proto=%0d, required 1 '{%0d,%0d} 0 0",
                     ok, sent, mon_bad, proto_err, b0, b1);
        end else begin
            n_checks++;
            if (sent[0] != b0 || sent[1] != b1) begin
                n_fail++;
                $display("FAIL retry_order: sent=%p, required '{%0d,%0d}", sent, b0, b1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int s0;
        logic [7:0] b;
        sent.delete(); mon_bad = 0; proto_err = 0;
        auto_xmt = 1'b1; tx_ready = 1'b1; frame_len = 176;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'($urandom);
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        n_checks++;
        if (count !== CW'(3) || busy !== 1'b1 || tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_queued: count=%0d busy=%b tx_ready=%b, required 3 1 0", count, busy, tx_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({count, empty, full, overflow, tx_start, tx_data, busy} !==
            {CW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL midframe_reset: count=%0d empty=%b full=%b ovf=%b start=%b data=%h busy=%b, required 0 1 0 0 0 00 0",
                     count, empty, full, overflow, tx_start, tx_data, busy);
        end
        s0 = n_starts;
        for (int i = 0; i < 400; i++) step();
        n_checks++;
        if (n_starts != s0 || empty !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL no_start_after_reset: starts=%0d empty=%b busy=%b, required 0 1 0", n_starts - s0, empty, busy);
        end
        sent.delete();
        b = 8'($urandom);
        wr_en = 1'b1; wr_data = b;
        step();
        wr_en = 1'b0;
        drain(600, ok);
        n_checks++;
        if (!ok || sent.size() != 1 || mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL midframe_restart: done=%b sent=%p mismatches=%0d proto=%0d (%s), required 1 '{%0d} 0 0",
                     ok, sent, mon_bad, proto_err, mon_msg, b);
        end
    endtask

    task automatic test_random();
        bit ok;
        int first_bad;
        int ovf_seen;
        sent.delete(); accepted.delete(); mon_bad = 0; proto_err = 0; ovf_seen = 0;
        auto_xmt = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            frame_len = $urandom_range(1, 6);
            wr_en     = ($urandom_range(0, 99) < 35);
            wr_data   = 8'($urandom);
            step();
            if (overflow === 1'b1) ovf_seen++;
        end
        wr_en = 1'b0;
        drain(2000, ok);
        frame_len = 176;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL random_drain: done=%b, required 1", ok);
        end
        first_bad = -1;
        for (int i = 0; i < sent.size() && i < accepted.size(); i++)
            if (first_bad < 0 && sent[i] != accepted[i]) first_bad = i;
        n_checks++;
        if (sent.size() != accepted.size() || first_bad >= 0) begin
            n_fail++;
            $display("FAIL random_order: sent=%0d accepted=%0d first_bad_index=%0d, required equal and -1",
                     sent.size(), accepted.size(), first_bad);
        end
        n_checks++;
        if (mon_bad != 0 || proto_err != 0) begin
            n_fail++;
            $display("FAIL random_monitor: mismatches=%0d proto=%0d (%s), required 0 0", mon_bad, proto_err, mon_msg);
        end
        n_checks++;
        if (ovf_seen == 0) begin
            n_fail++;
            $display("FAIL random_overflow_seen: pulses=%0d, required >0", ovf_seen);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_ready = 1'b1;
        test_reset();
        test_min_latency();
        test_back_to_back();
        test_overflow();
        test_full_pop_push();
        test_retry();
        test_reset_mid_frame();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
